// File: rtl/adsr_envelope_poly.sv
// Polyphonic ADSR envelope: VOICES independent envelopes sharing rate/level settings, stepped on a programmable tick.
// State and amplitude update on the clk edge that ends a tick cycle; no backpressure, note edges are latched until consumed.
module adsr_envelope_poly #(
  parameter int WIDTH    = 31,
  parameter int VOICES   = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [VOICES-1:0]         note_on,
  input  logic                      hard_retrig,
  input  logic [WIDTH-1:0]          attack,
  input  logic [WIDTH-1:0]          decay,
  input  logic [WIDTH-1:0]          sustain,
  input  logic [WIDTH-1:0]          rel,
  input  logic [WIDTH-1:0]          max_amplitude,
  output logic [VOICES*WIDTH-1:0]   amp_out,
  output logic [VOICES-1:0]         active,
  output logic                      tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t            state_q [VOICES];
  logic [WIDTH-1:0]  amp_q   [VOICES];
  logic [WIDTH:0]    att_sum [VOICES];
  logic [CW-1:0]     cnt_q;
  logic [VOICES-1:0] prev_q;
  logic [VOICES-1:0] trig_q;
  logic [VOICES-1:0] fire;
  logic [VOICES-1:0] active_q;
  logic [WIDTH-1:0]  sus_eff;

  assign tick    = (cnt_q == TICK_LAST);
  // An edge landing in the tick cycle itself is honoured at that same tick.
  assign fire    = trig_q | (note_on & ~prev_q);
  assign sus_eff = (sustain < max_amplitude) ? sustain : max_amplitude;
  assign active  = active_q;

  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      att_sum[i] = {1'b0, amp_q[i]} + {1'b0, attack};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      prev_q <= '0;
      trig_q <= '0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + CNT_ONE;
      prev_q <= note_on;
      trig_q <= tick ? '0 : fire;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        state_q[i] <= IDLE;
        amp_q[i]   <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < VOICES; i++) begin
        if (fire[i]) begin
          state_q[i]  <= ATTACK;
          active_q[i] <= 1'b1;
          if (state_q[i] == IDLE || hard_retrig) amp_q[i] <= '0;
        end else if (!note_on[i] &&
                     (state_q[i] == ATTACK || state_q[i] == DECAY || state_q[i] == SUSTAIN)) begin
          state_q[i] <= RELEASE;
        end else begin
          case (state_q[i])
            IDLE: begin
              if (note_on[i]) begin
                state_q[i]  <= ATTACK;
                active_q[i] <= 1'b1;
                amp_q[i]    <= '0;
              end
            end
            ATTACK: begin
              if (attack == '0 || att_sum[i] >= {1'b0, max_amplitude}) begin
                amp_q[i]   <= max_amplitude;
                state_q[i] <= DECAY;
              end else begin
                amp_q[i] <= att_sum[i][WIDTH-1:0];
              end
            end
            DECAY: begin
              // Clamp at sus_eff before subtracting so the step can never underflow.
              if (decay == '0 || amp_q[i] <= sus_eff || decay >= amp_q[i] - sus_eff) begin
                amp_q[i]   <= sus_eff;
                state_q[i] <= SUSTAIN;
              end else begin
                amp_q[i] <= amp_q[i] - decay;
              end
            end
            SUSTAIN: amp_q[i] <= sus_eff;
            RELEASE: begin
              if (rel == '0 || amp_q[i] <= rel) begin
                amp_q[i]    <= '0;
                state_q[i]  <= IDLE;
                active_q[i] <= 1'b0;
              end else begin
                amp_q[i] <= amp_q[i] - rel;
              end
            end
            default: begin
              state_q[i]  <= IDLE;
              amp_q[i]    <= '0;
              active_q[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_amp
    assign amp_out[g*WIDTH +: WIDTH] = amp_q[g];
  end

endmodule

// File: tb/tb_adsr_envelope_poly.sv
// Directed bench for adsr_envelope_poly: expected per-tick amplitudes are queued as stimulus is applied and checked after each tick.
module tb_adsr_envelope_poly;
  localparam int WIDTH    = 8;
  localparam int VOICES   = 2;
  localparam int TICK_DIV = 4;

  logic                    clk;
  logic                    reset;
  logic [VOICES-1:0]       note_on;
  logic                    hard_retrig;
  logic [WIDTH-1:0]        attack, decay, sustain, rel, max_amplitude;
  logic [VOICES*WIDTH-1:0] amp_out;
  logic [VOICES-1:0]       active;
  logic                    tick;

  adsr_envelope_poly #(.WIDTH(WIDTH), .VOICES(VOICES), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .note_on(note_on), .hard_retrig(hard_retrig),
    .attack(attack), .decay(decay), .sustain(sustain), .rel(rel),
    .max_amplitude(max_amplitude), .amp_out(amp_out), .active(active), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    a0;
    int    a1;
    int    act;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   basic[10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  task automatic push(input string tag, input int a0, input int a1, input int act);
    exp_t e;
    e.tag = tag; e.a0 = a0; e.a1 = a1; e.act = act;
    sb.push_back(e);
  endtask

  task automatic push_basic(input string tag);
    for (int k = 0; k < 10; k++) push($sformatf("%s%0d", tag, k), basic[k], 0, 1);
  endtask

  // Each queued entry is consumed by the next tick; outputs are sampled 1ns after the edge ending it.
  task automatic drain();
    exp_t e;
    int   waited;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (tick !== 1'b1 && waited < 3*TICK_DIV);
      chk({e.tag, "_tick"}, {31'b0, tick}, 32'd1);
      @(posedge clk);
      #1;
      chk({e.tag, "_amp0"}, {24'b0, amp_out[7:0]},  e.a0);
      chk({e.tag, "_amp1"}, {24'b0, amp_out[15:8]}, e.a1);
      chk({e.tag, "_act"},  {30'b0, active},        e.act);
    end
  endtask

  // Reset is released at a negedge; tick must first rise after TICK_DIV-1 clock edges and last one cycle.
  task automatic first_tick(input string tag);
    int n;
    n = 0;
    while (n < 3*TICK_DIV) begin
      @(posedge clk);
      #1;
      n++;
      if (tick === 1'b1) break;
    end
    chk({tag, "_edges"}, n, TICK_DIV - 1);
    @(posedge clk);
    #1;
    chk({tag, "_strobe_len"}, {31'b0, tick}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    basic = '{0, 64, 128, 192, 200, 180, 160, 140, 120, 100};
    reset = 1'b1; note_on = '0; hard_retrig = 1'b0;
    attack = 8'd64; decay = 8'd20; sustain = 8'd100; rel = 8'd30; max_amplitude = 8'd200;
    #1 reset = 1'b0;
    #2;
    chk("rst_amp",    {16'b0, amp_out}, 32'd0);
    chk("rst_active", {30'b0, active},  32'd0);
    chk("rst_tick",   {31'b0, tick},    32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    first_tick("first_tick");
    chk("idle_amp",    {16'b0, amp_out}, 32'd0);
    chk("idle_active", {30'b0, active},  32'd0);

    // Basic ADSR into sustain
    note_on = 2'b01;
    push_basic("adsr");
    push("sus_hold", 100, 0, 1);
    drain();

    // Release to idle
    note_on = 2'b00;
    push("rel_hold", 100, 0, 1);
    push("rel70", 70, 0, 1);
    push("rel40", 40, 0, 1);
    push("rel10", 10, 0, 1);
    push("rel0", 0, 0, 0);
    push("idle0", 0, 0, 0);
    drain();

    // Soft retrigger from release at 70
    note_on = 2'b01;
    push_basic("adsr2_");
    drain();
    note_on = 2'b00;
    push("rel2_hold", 100, 0, 1);
    push("rel2_70", 70, 0, 1);
    drain();
    note_on = 2'b01;
    push("soft_70", 70, 0, 1);
    push("soft_134", 134, 0, 1);
    push("soft_198", 198, 0, 1);
    push("soft_200", 200, 0, 1);
    push("soft_dec180", 180, 0, 1);
    drain();

    // Hard retrigger from release
    note_on = 2'b00;
    push("rel3_hold", 180, 0, 1);
    push("rel3_150", 150, 0, 1);
    drain();
    hard_retrig = 1'b1;
    note_on = 2'b01;
    push("hard_0", 0, 0, 1);
    push("hard_64", 64, 0, 1);
    push("hard_128", 128, 0, 1);
    push("hard_192", 192, 0, 1);
    drain();

    // Saturation and zero-rate stages
    max_amplitude = 8'd255; attack = 8'd250;
    push("sat_255", 255, 0, 1);
    drain();
    decay = 8'd0;
    push("dec0_sus", 100, 0, 1);
    drain();
    rel = 8'd0;
    note_on = 2'b00;
    push("rel0_hold", 100, 0, 1);
    push("rel0_zero", 0, 0, 0);
    drain();
    attack = 8'd0;
    note_on = 2'b01;
    push("att0_entry", 0, 0, 1);
    push("att0_max", 255, 0, 1);
    push("dec0_sus2", 100, 0, 1);
    drain();
    sustain = 8'd240; max_amplitude = 8'd200;
    push("suseff_200a", 200, 0, 1);
    push("suseff_200b", 200, 0, 1);
    drain();

    // Short voice-1 pulse while voice 0 releases
    rel = 8'd30;
    note_on = 2'b00;
    push("v0rel_hold", 200, 0, 1);
    drain();
    @(posedge clk); #1 note_on = 2'b10;
    @(posedge clk); #1 note_on = 2'b00;
    push("pulse_att", 170, 0, 3);
    push("pulse_rel", 140, 0, 3);
    push("pulse_idle", 110, 0, 1);
    push("v0rel80", 80, 0, 1);
    push("v0rel50", 50, 0, 1);
    push("v0rel20", 20, 0, 1);
    push("v0rel0", 0, 0, 0);
    drain();

    // Asynchronous reset mid-attack
    attack = 8'd64; hard_retrig = 1'b0;
    note_on = 2'b01;
    push("att_0", 0, 0, 1);
    push("att_64", 64, 0, 1);
    drain();
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("arst_amp",    {16'b0, amp_out}, 32'd0);
    chk("arst_active", {30'b0, active},  32'd0);
    chk("arst_tick",   {31'b0, tick},    32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    first_tick("rst2_first_tick");
    chk("rst2_amp",    {16'b0, amp_out}, 32'd0);
    chk("rst2_active", {30'b0, active},  32'd1);
    push("rst2_64", 64, 0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
